// File: rtl/rbzero_pkg.sv
// Shared definitions for the rbzero register-load path: default widths,
// frame length, loader state encoding and the error-counter width.
package rbzero_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 24;
  localparam int FRAME_BITS = DEF_ADDR_W + DEF_DATA_W;
  localparam int ERR_W      = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Saturating increment used for the malformed-frame counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/spi_reg_loader_if.sv
// SPI pin bundle plus the register-write strobe bus of the loader.
// o_wr_en is a one-cycle strobe with no back-pressure: o_wr_addr/o_wr_data are
// valid in the cycle o_wr_en=1 and the consumer must accept them that cycle.
interface spi_reg_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24
);
  logic              i_sclk;
  logic              i_mosi;
  logic              i_ss_n;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;

  modport slave (
    input  i_sclk, i_mosi, i_ss_n,
    output o_wr_en, o_wr_addr, o_wr_data
  );

  modport master (
    output i_sclk, i_mosi, i_ss_n,
    input  o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a history flop
// that yields single-cycle rise/fall pulses aligned with the synced value.
module pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_reg_loader.sv
// Deserialises address+data SPI frames into one-cycle register write strobes,
// optionally holding each write in a single-entry buffer until vertical blanking.
module spi_reg_loader
  import rbzero_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_reg_loader_if.slave  bus,
  input  logic             i_vblank,
  input  logic             i_defer,
  output logic             o_pending,
  output logic [ERR_W-1:0] o_err_count,
  output state_t           o_state
);

  localparam int FRAME_LEN = ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_LEN + 1);

  logic sclk_rise, sclk_fall_unused, sclk_q_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;
  logic ss_rise, ss_fall, ss_q_unused;

  pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(bus.i_sclk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  // Same depth as sclk so mosi_q is the bit present at the detected sclk edge.
  pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(bus.i_mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d(bus.i_ss_n),
    .q(ss_q_unused), .rise(ss_rise), .fall(ss_fall)
  );

  state_t               state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [FRAME_LEN-1:0] shift_q;
  logic [ADDR_W-1:0]    pend_addr_q;
  logic [DATA_W-1:0]    pend_data_q;
  logic                 pending_q;
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic [ERR_W-1:0]     err_cnt_q;
  logic                 commit;

  assign commit = pending_q && (!i_defer || i_vblank);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pending_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (commit) begin
        wr_addr_q <= pend_addr_q;
        wr_data_q <= pend_data_q;
        wr_en_q   <= 1'b1;
        pending_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state_q <= IDLE;
            // A good frame set here overrides the commit's clear: last write wins.
            if (bit_cnt_q == CNT_FULL) begin
              pend_addr_q <= shift_q[FRAME_LEN-1:DATA_W];
              pend_data_q <= shift_q[DATA_W-1:0];
              pending_q   <= 1'b1;
            end else begin
              err_cnt_q <= sat_inc(err_cnt_q);
            end
          end else if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_LEN-2:0], mosi_q};
            if (bit_cnt_q != CNT_OVR) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign o_pending     = pending_q;
  assign o_err_count   = err_cnt_q;
  assign o_state       = state_q;

endmodule
